mult_32_seq: RTL and testbench



---
 rtl/mult_32_seq_if.sv | 21 ++
 rtl/mult_32_seq.sv | 102 ++++++++++
 tb/tb_mult_32_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_32_seq_if.sv
// Operand and product handshakes for mult_32_seq.
// master drives operands and accepts products; slave is the multiplier.
interface mult_32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult_32_seq.sv
// 32x32 unsigned shift-and-add multiplier, one add per cycle,
// built around a single adder_32 with valid/ready on both sides.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module mult_32_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  mult_32_seq_if.slave bus
);
  if (WIDTH != 32) begin : g_width_chk
    $error("mult_32_seq: WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [5:0]       cnt;
  logic             in_ready;
  logic             out_valid;

  logic [31:0] add_b;
  logic [31:0] sum;
  logic        c_out;

  assign add_b = p_lo[0] ? a_reg : 32'h0;

  adder_32 u_add (
    .a     (p_hi),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.multiplicand;
            p_lo     <= bus.multiplier;
            p_hi     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // carry-out is kept as the new top bit of p_hi
          p_hi <= {c_out, sum[31:1]};
          p_lo <= {sum[0], p_lo[31:1]};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.product   = {p_hi, p_lo};
endmodule

// File: tb/tb_mult_32_seq.sv
// Directed checks for mult_32_seq: latency, handshakes,
// back-pressure, abort, carry retention and random products.
module tb_mult_32_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_32_seq_if bus ();

  mult_32_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 80) begin
      step();
      n++;
    end
    bus.in_valid     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  // edges counted from the accept edge itself (accept edge = 1)
  task automatic wait_done(output int lat, output logic busy_rdy);
    lat      = 1;
    busy_rdy = 1'b0;
    while (!bus.out_valid && lat < 60) begin
      busy_rdy |= bus.in_ready;
      step();
      lat++;
    end
    busy_rdy |= bus.in_ready;
  endtask

  task automatic xfer();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp);
    int   lat;
    logic br;
    accept(a, b);
    wait_done(lat, br);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_prod"}, bus.product, exp);
    xfer();
  endtask

  initial begin
    int          lat;
    logic        br;
    int          ec;
    int          acc0;
    int          acc1;
    int          nacc;
    logic        acc;
    logic [31:0] ra;
    logic [31:0] rb;

    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    rst = 1'b0;
    step();

    // zero operands, fixed latency
    accept(32'd0, 32'd0);
    chk("zero_in_ready_after_acc", 64'(bus.in_ready), 64'd0);
    wait_done(lat, br);
    chk("zero_latency", 64'(lat), 64'd33);
    chk("zero_prod", bus.product, 64'd0);
    xfer();
    chk("zero_in_ready_after_xfer", 64'(bus.in_ready), 64'd1);
    chk("zero_out_valid_after_xfer", 64'(bus.out_valid), 64'd0);

    // 5*10, in_ready stays low while busy
    accept(32'd5, 32'd10);
    wait_done(lat, br);
    chk("m5x10_busy_ready", 64'(br), 64'd0);
    chk("m5x10_latency", 64'(lat), 64'd33);
    chk("m5x10_prod", bus.product, 64'd50);
    xfer();

    run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run("msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // back-pressure
    accept(32'd100, 32'd200);
    wait_done(lat, br);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_prod", bus.product, 64'd20000);
      step();
    end
    chk("bp_prod", bus.product, 64'd20000);
    xfer();
    chk("bp_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd0);

    // second pair while busy is ignored
    accept(32'd7, 32'd3);
    bus.in_valid     = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    wait_done(lat, br);
    bus.in_valid = 1'b0;
    chk("busy_ign_prod", bus.product, 64'd21);
    chk("busy_ign_latency", 64'(lat), 64'd33);
    xfer();

    // back-to-back accepts with ready/valid held high
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd4;
    ec   = 0;
    nacc = 0;
    acc0 = 0;
    acc1 = 0;
    while (nacc < 2 && ec < 100) begin
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      ec++;
      if (acc) begin
        if (nacc == 0) acc0 = ec;
        else acc1 = ec;
        nacc++;
      end
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_spacing", 64'(acc1 - acc0), 64'd34);
    wait_done(lat, br);
    chk("b2b_prod", bus.product, 64'd12);
    xfer();

    // abort during CALC, with in_valid asserted alongside rst
    accept(32'd55, 32'd66);
    for (int i = 0; i < 10; i++) step();
    rst              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.multiplicand = 32'd77;
    bus.multiplier   = 32'd77;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_product", bus.product, 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("abort_no_accept", 64'(bus.in_ready), 64'd1);
    run("after_abort", 32'd12, 32'd12, 64'd144);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      run("rand", ra, rb, {32'h0, ra} * {32'h0, rb});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
